button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Parametrised multi-channel input conditioner for active-high or active-low button/switch pads, such as the d-pad. It replaces bare pull-up input cells. For each channel it adds:
- synchronisation and per-channel polarity inversion,
- a tick-based debounce filter,
- edge pulses and optional hold-to-autorepeat,
- sticky pending flags with write-1-to-clear and a summary IRQ.

It sits between the pad cells and the GPIO/padin bus of the core, in the clk_sys domain.

Parameters:
N_CHANNELS, 4, number of independent input channels
SYNC_STAGES, 2, synchroniser depth (>=2)
INVERT_MASK, {N_CHANNELS{1'b0}}, bit i set: channel i pad is active-low
PRESCALE, 1024, clk_sys cycles per sample tick (>=1)
DEBOUNCE_TICKS, 8, consecutive disagreeing ticks before the stable state flips (>=1)
W_REPEAT, 8, width of the autorepeat delay/period configuration

Ports:
clk_sys  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pad  input  N_CHANNELS  raw asynchronous pad levels
repeat_en  input  N_CHANNELS  per-channel autorepeat enable
repeat_delay  input  W_REPEAT  ticks from press to first repeat
repeat_period  input  W_REPEAT  ticks between subsequent repeats
pending_clr  input  N_CHANNELS  write-1-to-clear strobe for pending
state  output  N_CHANNELS  debounced, polarity-corrected level (1 = pressed)
rise  output  N_CHANNELS  1-cycle pulse on debounced press
fall  output  N_CHANNELS  1-cycle pulse on debounced release
repeat  output  N_CHANNELS  1-cycle autorepeat pulse
pending  output  N_CHANNELS  sticky event flags
irq  output  1  OR of pending

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is asynchronous, active-low, on rst_n. All flops reset to 0: sync chain, prescaler, debounce counters, state, rise, fall, repeat, pending and repeat FSMs. irq is therefore 0 in reset.
- Sync and inversion:
  - pad passes through a SYNC_STAGES-deep flop chain.
  - cond[i] = sync_out[i] ^ INVERT_MASK[i].
  - Edges from power-up levels are not suppressed. A non-inverted channel whose pad is held high at reset reports a normal press once debounced.
- Prescaler:
  - Counts 0..PRESCALE-1 and asserts tick in the cycle the count equals PRESCALE-1, then wraps to 0.
  - PRESCALE=1 gives tick every cycle.
  - The prescaler is shared by all channels.
- Debounce, per channel, evaluated only on tick:
  - cond==state: counter cleared.
  - cond!=state and counter==DEBOUNCE_TICKS-1: state<=cond, counter<=0.
  - Otherwise counter increments.
  - Between ticks everything holds.
  - Counter width is clog2(DEBOUNCE_TICKS), minimum 1.
- Edges:
  - rise and fall are registered alongside state, so each is high for exactly the one cycle in which state first shows its new value.
  - rise and fall are never both high on one channel.
- Autorepeat FSM, per channel, with states IDLE, DELAY and PERIOD and a W_REPEAT-bit tick counter:
  - IDLE to DELAY on rise with repeat_en[i]=1; counter<=0.
  - DELAY, on tick: if counter==max(repeat_delay,1)-1, pulse repeat and go to PERIOD with counter<=0; else increment.
  - PERIOD, on tick: if counter==max(repeat_period,1)-1, pulse repeat with counter<=0; else increment.
  - Any state goes to IDLE on fall or repeat_en[i]=0; fall has priority over a coincident repeat, which is suppressed.
  - repeat_delay and repeat_period are sampled live. A change takes effect at the next compare.
- Pending:
  - pending[i] is set by rise[i] or repeat[i] and cleared by pending_clr[i].
  - Set wins over a simultaneous clear.
  - fall does not set pending.
- irq = |pending, driven combinationally from registers, so it carries no added latency.
- Press latency: from a pad edge to rise is at most SYNC_STAGES + PRESCALE*DEBOUNCE_TICKS + 1 cycles.
- Reset mid-operation: all outputs drop to 0 immediately. After release the debounce reconverges from state=0.

Decomposition:
- Package button_conditioner_pkg holds the repeat FSM state encoding (IDLE=2'd0, DELAY=2'd1, PERIOD=2'd2) and a clog2 helper constant function.
- Sub-module button_channel contains one channel's debounce counter, state/edge registers, repeat FSM and pending flag.
  - It takes tick, cond and the configuration as inputs.
  - The top instantiates it N_CHANNELS times in a generate loop, alongside the shared synchroniser and prescaler.

Test Plan:
Unless a scenario says otherwise, the bench uses PRESCALE=4, DEBOUNCE_TICKS=3 and INVERT_MASK=4'b0100, with pad reset to 4'b0100.
1. Reset: hold rst_n=0 with arbitrary pad -> all outputs 0. Release with pad=4'b0100 -> state stays 4'b0000 and no pulses for 200 cycles.
2. Clean press: pad[0] 0->1 and held -> state[0]=1 within 2+12+1=15 cycles, a single 1-cycle rise[0], pending[0]=1, irq=1. pending_clr[0]=1 -> pending[0]=0 and irq=0 the next cycle.
3. Bounce: toggle pad[1] every 6 cycles for 120 cycles, shorter than 3 ticks (12 cycles) -> state[1], rise[1] and fall[1] never assert. Then hold pad[1] steady at 1 -> press reported once.
4. Inversion: drive pad[2] low -> state[2]=1 and rise[2]. Drive it high -> fall[2], with pending[2] unaffected by the release.
5. Autorepeat: repeat_en[3]=1, repeat_delay=5, repeat_period=2, hold pad[3] for 20 ticks -> repeat pulses at ticks 5, 7, 9, ... after rise. Release -> no repeat after fall and the FSM returns to IDLE. A repeat_delay=0 run behaves as delay 1.
6. Collision and reset: assert pending_clr[3] in the same cycle as repeat[3] -> pending[3] stays 1. Assert rst_n=0 mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: autorepeat FSM encoding and a
// width helper used to size the prescaler and debounce counters.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_PERIOD = 2'd2
  } rpt_state_e;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One conditioned input: tick-based debounce, edge pulses, hold-to-autorepeat
// FSM and a sticky pending flag with write-1-to-clear.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 8,
  parameter int W_REPEAT       = 8
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                i_tick,
  input  logic                i_cond,
  input  logic                i_repeat_en,
  input  logic [W_REPEAT-1:0] i_repeat_delay,
  input  logic [W_REPEAT-1:0] i_repeat_period,
  input  logic                i_pending_clr,
  output logic                o_state,
  output logic                o_rise,
  output logic                o_fall,
  output logic                o_repeat,
  output logic                o_pending,
  output rpt_state_e          o_rpt_state
);

  localparam int CW = clog2_min1(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [CW-1:0]       r_db_cnt;
  logic                r_state;
  logic                r_rise;
  logic                r_fall;
  logic                r_repeat;
  logic                r_pending;
  rpt_state_e          r_rpt_state;
  rpt_state_e          w_rpt_state_nxt;
  logic [W_REPEAT-1:0] r_rpt_cnt;
  logic [W_REPEAT-1:0] w_rpt_cnt_nxt;
  logic                w_repeat_ev;
  logic                w_flip;
  logic                w_rise_ev;
  logic                w_fall_ev;
  logic [W_REPEAT-1:0] w_delay_last;
  logic [W_REPEAT-1:0] w_period_last;

  assign w_flip    = i_tick && (i_cond != r_state) && (r_db_cnt == DB_LAST);
  assign w_rise_ev = w_flip & i_cond;
  assign w_fall_ev = w_flip & ~i_cond;

  // A programmed delay/period of zero behaves as one tick.
  assign w_delay_last  = (i_repeat_delay == '0)  ? '0 : i_repeat_delay - W_REPEAT'(1);
  assign w_period_last = (i_repeat_period == '0) ? '0 : i_repeat_period - W_REPEAT'(1);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_state  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= w_rise_ev;
      r_fall <= w_fall_ev;
      if (i_tick) begin
        if (i_cond == r_state) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
          r_state  <= i_cond;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + CW'(1);
        end
      end
    end
  end

  // The FSM reacts to the edge events in the same cycle the state register
  // updates, so a release always wins over a repeat falling on that tick.
  always_comb begin
    w_rpt_state_nxt = r_rpt_state;
    w_rpt_cnt_nxt   = r_rpt_cnt;
    w_repeat_ev     = 1'b0;
    if (w_fall_ev || !i_repeat_en) begin
      w_rpt_state_nxt = RPT_IDLE;
      w_rpt_cnt_nxt   = '0;
    end else begin
      case (r_rpt_state)
        RPT_IDLE: begin
          if (w_rise_ev) begin
            w_rpt_state_nxt = RPT_DELAY;
            w_rpt_cnt_nxt   = '0;
          end
        end
        RPT_DELAY: begin
          if (i_tick) begin
            if (r_rpt_cnt == w_delay_last) begin
              w_repeat_ev     = 1'b1;
              w_rpt_state_nxt = RPT_PERIOD;
              w_rpt_cnt_nxt   = '0;
            end else begin
              w_rpt_cnt_nxt = r_rpt_cnt + W_REPEAT'(1);
            end
          end
        end
        RPT_PERIOD: begin
          if (i_tick) begin
            if (r_rpt_cnt == w_period_last) begin
              w_repeat_ev   = 1'b1;
              w_rpt_cnt_nxt = '0;
            end else begin
              w_rpt_cnt_nxt = r_rpt_cnt + W_REPEAT'(1);
            end
          end
        end
        default: begin
          w_rpt_state_nxt = RPT_IDLE;
          w_rpt_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_state <= RPT_IDLE;
      r_rpt_cnt   <= '0;
      r_repeat    <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      r_rpt_state <= w_rpt_state_nxt;
      r_rpt_cnt   <= w_rpt_cnt_nxt;
      r_repeat    <= w_repeat_ev;
      // Set from the visible pulses; a set beats a simultaneous clear.
      if (r_rise || r_repeat) begin
        r_pending <= 1'b1;
      end else if (i_pending_clr) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_state     = r_state;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign o_repeat    = r_repeat;
  assign o_pending   = r_pending;
  assign o_rpt_state = r_rpt_state;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel pad conditioner: shared synchroniser and sample-tick prescaler
// feeding one button_channel per input, plus the summary interrupt.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int                    N_CHANNELS     = 4,
  parameter int                    SYNC_STAGES    = 2,
  parameter logic [N_CHANNELS-1:0] INVERT_MASK    = {N_CHANNELS{1'b0}},
  parameter int                    PRESCALE       = 1024,
  parameter int                    DEBOUNCE_TICKS = 8,
  parameter int                    W_REPEAT       = 8
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic [N_CHANNELS-1:0]   pad,
  input  logic [N_CHANNELS-1:0]   repeat_en,
  input  logic [W_REPEAT-1:0]     repeat_delay,
  input  logic [W_REPEAT-1:0]     repeat_period,
  input  logic [N_CHANNELS-1:0]   pending_clr,
  output logic [N_CHANNELS-1:0]   state,
  output logic [N_CHANNELS-1:0]   rise,
  output logic [N_CHANNELS-1:0]   fall,
  output logic [N_CHANNELS-1:0]   repeat_pulse,
  output logic [N_CHANNELS-1:0]   pending,
  output logic                    irq,
  output logic [2*N_CHANNELS-1:0] rpt_state_dbg
);

  localparam int PW = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [SYNC_STAGES-1:0][N_CHANNELS-1:0] r_sync;
  logic [N_CHANNELS-1:0]                  w_cond;
  logic [PW-1:0]                          r_presc;
  logic                                   w_tick;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pad};
    end
  end

  assign w_cond = r_sync[SYNC_STAGES-1] ^ INVERT_MASK;

  assign w_tick = (r_presc == PRE_LAST);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
    rpt_state_e w_ch_rpt;

    button_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .W_REPEAT       (W_REPEAT)
    ) u_channel (
      .clk_sys         (clk_sys),
      .rst_n           (rst_n),
      .i_tick          (w_tick),
      .i_cond          (w_cond[g]),
      .i_repeat_en     (repeat_en[g]),
      .i_repeat_delay  (repeat_delay),
      .i_repeat_period (repeat_period),
      .i_pending_clr   (pending_clr[g]),
      .o_state         (state[g]),
      .o_rise          (rise[g]),
      .o_fall          (fall[g]),
      .o_repeat        (repeat_pulse[g]),
      .o_pending       (pending[g]),
      .o_rpt_state     (w_ch_rpt)
    );

    assign rpt_state_dbg[2*g +: 2] = w_ch_rpt;
  end

  assign irq = |pending;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with PRESCALE=4, DEBOUNCE_TICKS=3 and
// channel 2 active-low; outputs are sampled on the falling clock edge.
module tb_button_conditioner;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [3:0] pad           = 4'b0100;
  logic [3:0] repeat_en     = 4'b0000;
  logic [7:0] repeat_delay  = 8'd5;
  logic [7:0] repeat_period = 8'd2;
  logic [3:0] pending_clr   = 4'b0000;
  logic [3:0] state;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] repeat_pulse;
  logic [3:0] pending;
  logic       irq;
  logic [7:0] rpt_state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  button_conditioner #(
    .N_CHANNELS     (4),
    .SYNC_STAGES    (2),
    .INVERT_MASK    (4'b0100),
    .PRESCALE       (4),
    .DEBOUNCE_TICKS (3),
    .W_REPEAT       (8)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .pad           (pad),
    .repeat_en     (repeat_en),
    .repeat_delay  (repeat_delay),
    .repeat_period (repeat_period),
    .pending_clr   (pending_clr),
    .state         (state),
    .rise          (rise),
    .fall          (fall),
    .repeat_pulse  (repeat_pulse),
    .pending       (pending),
    .irq           (irq),
    .rpt_state_dbg (rpt_state_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic sel(input int which, input int ch);
    case (which)
      0:       return state[ch];
      1:       return ~state[ch];
      2:       return rise[ch];
      3:       return fall[ch];
      default: return repeat_pulse[ch];
    endcase
  endfunction

  // Bounded wait; cycles = -1 when the event never shows up.
  task automatic wait_for(input int which, input int ch, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk_sys);
      if (sel(which, ch)) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    pad   = 4'b1011;
    repeat (3) @(negedge clk_sys);
    n_cmp++;
    if ({state, rise, fall, repeat_pulse, pending, irq, rpt_state_dbg} !== 29'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {state, rise, fall, repeat_pulse, pending, irq, rpt_state_dbg});
    end
    pad = 4'b0100;
    @(negedge clk_sys);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if ({state, rise, fall, repeat_pulse, pending} !== 20'd0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_clean_press();
    int lat;
    int nr;
    pad[0] = 1'b1;
    wait_for(0, 0, 40, lat);
    n_cmp++;
    if (!(lat >= 1 && lat <= 15)) begin
      n_err++;
      $display("FAIL press_latency: got %0d cycles expected 1..15", lat);
    end
    n_cmp++;
    if (rise[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rise0_with_state: got %b expected 1", rise[0]);
    end
    @(negedge clk_sys);
    n_cmp++;
    if (rise[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rise0_one_cycle: got %b expected 0", rise[0]);
    end
    n_cmp++;
    if (pending[0] !== 1'b1) begin
      n_err++;
      $display("FAIL pending0_set: got %b expected 1", pending[0]);
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_set: got %b expected 1", irq);
    end
    pending_clr[0] = 1'b1;
    @(negedge clk_sys);
    pending_clr[0] = 1'b0;
    n_cmp++;
    if (pending[0] !== 1'b0) begin
      n_err++;
      $display("FAIL pending0_clear: got %b expected 0", pending[0]);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear: got %b expected 0", irq);
    end
    nr = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_sys);
      if (rise[0] || fall[0]) nr++;
    end
    n_cmp++;
    if (nr !== 0) begin
      n_err++;
      $display("FAIL press_no_extra_edges: got %0d expected 0", nr);
    end
  endtask

  task automatic test_bounce();
    int bad;
    int nr;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      pad[1] = ~pad[1];
      repeat (6) begin
        @(negedge clk_sys);
        if (state[1] || rise[1] || fall[1]) bad++;
      end
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL bounce_filtered: got %0d active cycles expected 0", bad);
    end
    pad[1] = 1'b1;
    nr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (rise[1]) nr++;
    end
    n_cmp++;
    if (nr !== 1) begin
      n_err++;
      $display("FAIL bounce_settled_rise_count: got %0d expected 1", nr);
    end
    n_cmp++;
    if (state[1] !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_settled_state: got %b expected 1", state[1]);
    end
  endtask

  task automatic test_inversion();
    int lat;
    pad[2] = 1'b0;
    wait_for(0, 2, 40, lat);
    n_cmp++;
    if (lat < 1 || rise[2] !== 1'b1) begin
      n_err++;
      $display("FAIL inv_press: got lat=%0d rise=%b expected rise=1", lat, rise[2]);
    end
    @(negedge clk_sys);
    pending_clr[2] = 1'b1;
    @(negedge clk_sys);
    pending_clr[2] = 1'b0;
    n_cmp++;
    if (pending[2] !== 1'b0) begin
      n_err++;
      $display("FAIL inv_pending_clear: got %b expected 0", pending[2]);
    end
    pad[2] = 1'b1;
    wait_for(1, 2, 40, lat);
    n_cmp++;
    if (lat < 1 || fall[2] !== 1'b1 || rise[2] !== 1'b0) begin
      n_err++;
      $display("FAIL inv_release: got lat=%0d fall=%b rise=%b expected fall=1 rise=0",
               lat, fall[2], rise[2]);
    end
    repeat (5) @(negedge clk_sys);
    n_cmp++;
    if (pending[2] !== 1'b0) begin
      n_err++;
      $display("FAIL inv_fall_no_pending: got %b expected 0", pending[2]);
    end
  endtask

  task automatic test_autorepeat();
    int lat;
    int nr;
    int got_q[$];
    int exp_q[$];
    exp_q = '{20, 28, 36, 44, 52, 60, 68, 76};
    repeat_en     = 4'b1000;
    repeat_delay  = 8'd5;
    repeat_period = 8'd2;
    pad[3] = 1'b1;
    wait_for(2, 3, 40, lat);
    n_cmp++;
    if (lat < 1 || rpt_state_dbg[7:6] !== 2'd1) begin
      n_err++;
      $display("FAIL rpt_enter_delay: got lat=%0d fsm=%0d expected fsm=1", lat, rpt_state_dbg[7:6]);
    end
    for (int off = 1; off <= 80; off++) begin
      @(negedge clk_sys);
      if (repeat_pulse[3]) got_q.push_back(off);
      if (off == 21) begin
        n_cmp++;
        if (rpt_state_dbg[7:6] !== 2'd2) begin
          n_err++;
          $display("FAIL rpt_in_period: got %0d expected 2", rpt_state_dbg[7:6]);
        end
      end
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL rpt_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL rpt_offset[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
        end
      end
    end
    pad[3] = 1'b0;
    wait_for(3, 3, 40, lat);
    n_cmp++;
    if (lat < 1 || repeat_pulse[3] !== 1'b0 || rpt_state_dbg[7:6] !== 2'd0) begin
      n_err++;
      $display("FAIL rpt_release: got lat=%0d repeat=%b fsm=%0d expected repeat=0 fsm=0",
               lat, repeat_pulse[3], rpt_state_dbg[7:6]);
    end
    nr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (repeat_pulse[3]) nr++;
    end
    n_cmp++;
    if (nr !== 0) begin
      n_err++;
      $display("FAIL rpt_after_fall: got %0d pulses expected 0", nr);
    end
  endtask

  task automatic test_repeat_delay_zero();
    int lat;
    int got_q[$];
    int exp_q[$];
    exp_q = '{4, 12};
    repeat_delay = 8'd0;
    pad[3] = 1'b1;
    wait_for(2, 3, 40, lat);
    for (int off = 1; off <= 14; off++) begin
      @(negedge clk_sys);
      if (repeat_pulse[3]) got_q.push_back(off);
    end
    n_cmp++;
    if (lat < 1 || got_q.size() !== 2) begin
      n_err++;
      $display("FAIL rpt0_count: got lat=%0d pulses=%0d expected 2", lat, got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rpt0_offset[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_collision_reset();
    int lat;
    wait_for(4, 3, 20, lat);
    @(negedge clk_sys);
    pending_clr[3] = 1'b1;
    @(negedge clk_sys);
    pending_clr[3] = 1'b0;
    n_cmp++;
    if (lat < 1 || pending[3] !== 1'b0) begin
      n_err++;
      $display("FAIL coll_plain_clear: got lat=%0d pending=%b expected pending=0", lat, pending[3]);
    end
    wait_for(4, 3, 20, lat);
    pending_clr[3] = 1'b1;
    @(negedge clk_sys);
    pending_clr[3] = 1'b0;
    n_cmp++;
    if (lat < 1 || pending[3] !== 1'b1 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL coll_set_wins: got lat=%0d pending=%b irq=%b expected 1/1", lat, pending[3], irq);
    end
    @(negedge clk_sys);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({state, rise, fall, repeat_pulse, pending, irq, rpt_state_dbg} !== 29'd0) begin
      n_err++;
      $display("FAIL midrun_reset: got %h expected 0",
               {state, rise, fall, repeat_pulse, pending, irq, rpt_state_dbg});
    end
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    wait_for(2, 3, 40, lat);
    n_cmp++;
    if (lat < 1) begin
      n_err++;
      $display("FAIL reconverge_rise: got %0d expected a rise within 40 cycles", lat);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_inversion();
    test_autorepeat();
    test_repeat_delay_zero();
    test_collision_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
